lvda_timing_gen: RTL and testbench
==================================

// Module: lvda_timing_gen
// PURPOSE
// - Master timing generator for the LVDA: divides SIM_CLK into the four non-overlapping
//   phase drives WDA, XDA, YDA, ZDA consumed by the phase fan-out buffers, and tracks bit time.
// - Runs/stops cleanly on word boundaries; provides bit-time index and word-end strobe to sequencing logic.
// PARAMETERS
// - DIV       4   SIM_CLK cycles per phase slot (>=2)
// - PULSE_W   2   cycles each phase drive is high within its slot (1..DIV-1; guarantees gap)
// - BIT_COUNT 14  bit times per word (2..16)
// PORTS
// - SIM_CLK   in   1  single system clock; all state on rising edge
// - SIM_RST   in   1  reset, asynchronous, active-low
// - RUN       in   1  level run enable
// - WDA       out  1  W phase drive
// - XDA       out  1  X phase drive
// - YDA       out  1  Y phase drive
// - ZDA       out  1  Z phase drive
// - BT        out  4  current bit-time index 0..BIT_COUNT-1
// - WORD_END  out  1  1-cycle strobe, last cycle of Z slot of last bit time
// - STOPPED   out  1  high while generator idle
// BEHAVIOUR
// - Reset (SIM_RST=0, async): state IDLE; WDA/XDA/YDA/ZDA=0, BT=0, WORD_END=0, STOPPED=1.
// - Counters: slot cnt 0..DIV-1, phase idx 0..3 (W,X,Y,Z), bit cnt 0..BIT_COUNT-1.
//   slot wraps -> phase++; phase Z wraps -> W and bit++; bit wraps BIT_COUNT-1 -> 0.
// - Drive of phase p = (state!=IDLE) && phase==p && slot<PULSE_W; all outputs registered.
// - At most one of WDA..ZDA high in any cycle; >= DIV-PULSE_W low cycles between drives.
// - States: IDLE, RUN, DRAIN.
//   IDLE: counters held 0; RUN=1 sampled at edge n -> RUN, WDA=1 after edge n+1 (latency 1), STOPPED=0.
//   RUN: counters advance every cycle; RUN=0 sampled -> DRAIN (no truncation of current word).
//   DRAIN: counters keep advancing; RUN=1 again -> RUN, no gap or restart;
//          on WORD_END cycle with RUN=0 -> IDLE, counters cleared, STOPPED=1 next cycle.
// - RUN=0 on the WORD_END cycle in RUN: go directly to IDLE (word already complete).
// - RUN held high: continuous words, bit 0 W follows last-bit Z with no extra cycle.
// - BT updates on the first cycle of the W slot of each bit; stable through X,Y,Z.
// - WORD_END = slot==DIV-1 && phase==Z && bit==BIT_COUNT-1 && state!=IDLE.
// - Async reset mid-word: outputs drop immediately, restart from bit 0 W after release and RUN.
// CONFIGURATION
// - TIMING_SINGLE_STEP_EN defined: adds input STEP (1 bit). When RUN=0 and in IDLE, a
//   1-cycle STEP pulse runs exactly one bit time (W..Z of BT, then BT+1, wrapping) and
//   returns to IDLE with BT retained (not cleared); WORD_END fires only if stepped bit is last.
//   STEP ignored outside IDLE or while RUN=1. RUN entry from IDLE resumes from retained BT.
// - Not defined: no STEP port; IDLE always clears BT to 0; RUN-only operation as above.
// TESTING
// - Reset, RUN=0 for 20 cycles -> all drives 0, BT=0, STOPPED=1, WORD_END never high.
// - Defaults, RUN=1 at cycle 0 -> WDA high cycles 1-2, XDA 5-6, YDA 9-10, ZDA 13-14;
//   BT=1 from cycle 17; WORD_END at cycle 224; BT=0 at cycle 225, no gap.
// - RUN dropped mid bit 5 -> drives continue through bit 13 Z; WORD_END once; STOPPED=1
//   next cycle; RUN re-raised in DRAIN at bit 9 -> no stop, sequence unbroken.
// - SIM_RST pulsed low during YDA of bit 7 -> YDA drops same cycle; after release with RUN=1
//   sequence restarts at BT=0 WDA, one cycle after first RUN sample.
// - Sweep DIV=2..6, PULSE_W=1..DIV-1 -> one-hot-or-zero check on drives every cycle,
//   gap >= DIV-PULSE_W, word length = 4*DIV*BIT_COUNT cycles.
// - With TIMING_SINGLE_STEP_EN: three STEP pulses from reset -> three W..Z sets, BT 0->3,
//   STOPPED=1 between steps; STEP during RUN=1 -> no effect.

Source files
------------

// File: rtl/lvda_timing_gen.sv
// LVDA master timing generator: four non-overlapping phase drives, bit-time index, word-end strobe.
// Optional single-step mode: define TIMING_SINGLE_STEP_EN to add the STEP input.
module lvda_timing_gen #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned PULSE_W   = 2,
  parameter int unsigned BIT_COUNT = 14
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       RUN,
`ifdef TIMING_SINGLE_STEP_EN
  input  logic       STEP,
`endif
  output logic       WDA,
  output logic       XDA,
  output logic       YDA,
  output logic       ZDA,
  output logic [3:0] BT,
  output logic       WORD_END,
  output logic       STOPPED
);

  localparam int unsigned SW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0] BIT_LAST = 4'(BIT_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StStep} state_e;

  state_e         state_q, state_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic [1:0]     phase_q, phase_d;
  logic [3:0]     bit_q, bit_d;
  logic [3:0]     drv_q, drv_c;
  logic [3:0]     bt_q;
  logic           word_end_q, word_end_c;
  logic           stopped_q;
  logic           slot_last, bit_end, step_req;

  assign slot_last = (slot_q == SW'(DIV - 1));
  assign bit_end   = slot_last && (phase_q == 2'd3);

`ifdef TIMING_SINGLE_STEP_EN
  assign step_req = STEP && !RUN;
`else
  assign step_req = 1'b0;
`endif

  // State register
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stopping is only allowed once the current word has completed
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (RUN) begin
          state_d = StRun;
        end else if (step_req) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (!RUN) begin
          state_d = word_end_c ? StIdle : StDrain;
        end
      end
      StDrain: begin
        if (RUN) begin
          state_d = StRun;
        end else if (word_end_c) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        if (bit_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    drv_c      = 4'b0000;
    word_end_c = 1'b0;
    if (state_q != StIdle) begin
      if (slot_q < SW'(PULSE_W)) begin
        drv_c = 4'b1000 >> phase_q;
      end
      word_end_c = bit_end && (bit_q == BIT_LAST);
    end
  end

  // Slot / phase / bit counters
  always_comb begin
    slot_d  = slot_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    if (state_q == StIdle) begin
      slot_d  = '0;
      phase_d = 2'd0;
`ifndef TIMING_SINGLE_STEP_EN
      bit_d   = 4'd0;
`endif
    end else if (slot_last) begin
      slot_d  = '0;
      phase_d = phase_q + 2'd1;
      if (phase_q == 2'd3) begin
        bit_d = (bit_q == BIT_LAST) ? 4'd0 : bit_q + 4'd1;
      end
    end else begin
      slot_d = slot_q + SW'(1);
    end
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      slot_q     <= '0;
      phase_q    <= 2'd0;
      bit_q      <= 4'd0;
      drv_q      <= 4'b0000;
      bt_q       <= 4'd0;
      word_end_q <= 1'b0;
      stopped_q  <= 1'b1;
    end else begin
      slot_q     <= slot_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      drv_q      <= drv_c;
      bt_q       <= bit_q;
      word_end_q <= word_end_c;
      stopped_q  <= (state_q == StIdle);
    end
  end

  assign WDA      = drv_q[3];
  assign XDA      = drv_q[2];
  assign YDA      = drv_q[1];
  assign ZDA      = drv_q[0];
  assign BT       = bt_q;
  assign WORD_END = word_end_q;
  assign STOPPED  = stopped_q;

endmodule

// File: tb/tb_lvda_timing_gen.sv
// Self-checking bench for lvda_timing_gen: default instance plus three swept-parameter instances,
// compared each cycle against a linear-position reference model.
module tb_lvda_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m, run_m, rst_s, run_s;
  logic step_m;
  int   n_checks = 0;
  int   n_fail   = 0;

  // obs bits: [9]=W [8]=X [7]=Y [6]=Z [5:2]=BT [1]=WORD_END [0]=STOPPED
  logic [9:0] obs [4];

  function automatic int unsigned div_of(int i);
    case (i)
      0: return 4;
      1: return 2;
      2: return 3;
      default: return 6;
    endcase
  endfunction

  function automatic int unsigned pw_of(int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 2;
      default: return 5;
    endcase
  endfunction

  function automatic int unsigned bc_of(int i);
    case (i)
      0: return 14;
      1: return 2;
      2: return 4;
      default: return 3;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned GD = div_of(g);
    localparam int unsigned GP = pw_of(g);
    localparam int unsigned GB = bc_of(g);
    logic       w, x, y, z, we, st;
    logic [3:0] bt;
    lvda_timing_gen #(.DIV(GD), .PULSE_W(GP), .BIT_COUNT(GB)) u_dut (
      .SIM_CLK  (clk),
      .SIM_RST  (g == 0 ? rst_m : rst_s),
      .RUN      (g == 0 ? run_m : run_s),
`ifdef TIMING_SINGLE_STEP_EN
      .STEP     (g == 0 ? step_m : 1'b0),
`endif
      .WDA      (w),
      .XDA      (x),
      .YDA      (y),
      .ZDA      (z),
      .BT       (bt),
      .WORD_END (we),
      .STOPPED  (st)
    );
    assign obs[g] = {w, x, y, z, bt, we, st};
  end

  // Reference model: the generator is either idle or at linear position t within a word.
  bit         m_act [4];
  int         m_t   [4];
  logic [9:0] m_exp [4];

  function automatic logic [9:0] model_out(bit act, int t, int i);
    int d, p, b, slot, ph, bitn, len;
    logic [3:0] drv;
    logic [3:0] btv;
    d    = int'(div_of(i));
    p    = int'(pw_of(i));
    b    = int'(bc_of(i));
    len  = 4 * d * b;
    slot = t % d;
    ph   = (t / d) % 4;
    bitn = (t / (4 * d)) % b;
    drv  = 4'b0000;
    if (act && slot < p) drv[3-ph] = 1'b1;
    btv = act ? 4'(bitn) : 4'd0;
    return {drv, btv, act && (t == len - 1), !act};
  endfunction

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      logic r, rn;
      int len;
      r   = (i == 0) ? rst_m : rst_s;
      rn  = (i == 0) ? run_m : run_s;
      len = int'(4 * div_of(i) * bc_of(i));
      if (!r) begin
        m_act[i] = 1'b0;
        m_t[i]   = 0;
        m_exp[i] = 10'h001;
      end else begin
        m_exp[i] = model_out(m_act[i], m_t[i], i);
        if (!m_act[i]) begin
          m_act[i] = rn;
          m_t[i]   = 0;
        end else if (m_t[i] == len - 1 && !rn) begin
          m_act[i] = 1'b0;
          m_t[i]   = 0;
        end else begin
          m_t[i] = (m_t[i] + 1) % len;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_m = 1'b0; rst_s = 1'b0; run_m = 1'b0; run_s = 1'b0; step_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 1'b0; m_t[i] = 0; m_exp[i] = 10'h001;
    end
    #12;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs[i] !== 10'h001) begin
        n_fail++;
        $display("FAIL reset_state inst=%0d got=%b want=%b", i, obs[i], 10'h001);
      end
    end
    @(negedge clk);
    rst_m = 1'b1; rst_s = 1'b1;
    for (int c = 0; c < 20; c++) begin
      advance();
      n_checks++;
      if (obs[0] !== 10'h001 || obs[0] !== m_exp[0]) begin
        n_fail++;
        $display("FAIL idle_hold cyc=%0d got=%b want=%b", c, obs[0], m_exp[0]);
      end
    end
  endtask

  task automatic test_start();
    logic [3:0] want;
    run_m = 1'b1;
    for (int c = 0; c < 260; c++) begin
      advance();
      n_checks++;
      if (obs[0] !== m_exp[0]) begin
        n_fail++;
        $display("FAIL start_model cyc=%0d got=%b want=%b", c, obs[0], m_exp[0]);
      end
      if (c <= 16) begin
        want = 4'b0000;
        if (c == 1 || c == 2)   want = 4'b1000;
        if (c == 5 || c == 6)   want = 4'b0100;
        if (c == 9 || c == 10)  want = 4'b0010;
        if (c == 13 || c == 14) want = 4'b0001;
        n_checks++;
        if (obs[0][9:6] !== want) begin
          n_fail++;
          $display("FAIL start_drives cyc=%0d got=%b want=%b", c, obs[0][9:6], want);
        end
      end
      if (c == 17) begin
        n_checks++;
        if (obs[0][5:2] !== 4'd1) begin
          n_fail++;
          $display("FAIL start_bt1 got=%0d want=1", obs[0][5:2]);
        end
      end
      if (c == 224) begin
        n_checks++;
        if (obs[0][1] !== 1'b1) begin
          n_fail++;
          $display("FAIL start_word_end got=%b want=1", obs[0][1]);
        end
      end
      if (c == 225) begin
        n_checks++;
        if (obs[0][5:2] !== 4'd0 || obs[0][9] !== 1'b1 || obs[0][0] !== 1'b0) begin
          n_fail++;
          $display("FAIL start_wrap got=%b want=W=1 BT=0 STOPPED=0", obs[0]);
        end
      end
    end
  endtask

  task automatic test_drain();
    int  we_cnt;
    bit  prev_we, done;
    run_m = 1'b0;
    done  = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      advance();
      n_checks++;
      if (obs[0] !== m_exp[0]) begin
        n_fail++;
        $display("FAIL drain_settle cyc=%0d got=%b want=%b", c, obs[0], m_exp[0]);
      end
      if (!m_act[0] && obs[0][0] === 1'b1) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_settle_timeout stopped=%b want=1", obs[0][0]);
    end
    run_m = 1'b1;
    for (int c = 0; c < 311; c++) begin
      advance();
      n_checks++;
      if (obs[0] !== m_exp[0]) begin
        n_fail++;
        $display("FAIL drain_model cyc=%0d got=%b want=%b", c, obs[0], m_exp[0]);
      end
      if (c == 226) begin
        n_checks++;
        if (obs[0][0] !== 1'b0 || obs[0][5:2] !== 4'd0) begin
          n_fail++;
          $display("FAIL drain_rearm got=%b want=running BT=0", obs[0]);
        end
      end
      if (c == 86)  run_m = 1'b0;
      if (c == 147) run_m = 1'b1;
      if (c == 310) run_m = 1'b0;
    end
    we_cnt  = 0;
    prev_we = 1'b0;
    done    = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      advance();
      n_checks++;
      if (obs[0] !== m_exp[0]) begin
        n_fail++;
        $display("FAIL drain_stop_model cyc=%0d got=%b want=%b", c, obs[0], m_exp[0]);
      end
      if (prev_we) begin
        done = 1'b1;
        n_checks++;
        if (obs[0][0] !== 1'b1) begin
          n_fail++;
          $display("FAIL drain_stopped_after_we got=%b want=1", obs[0][0]);
        end
      end
      if (obs[0][1] === 1'b1) we_cnt++;
      prev_we = obs[0][1];
    end
    n_checks++;
    if (we_cnt != 1 || !done) begin
      n_fail++;
      $display("FAIL drain_word_end_count got=%0d want=1 done=%0d", we_cnt, done);
    end
  endtask

  task automatic test_reset_mid();
    run_m = 1'b1;
    for (int c = 0; c <= 121; c++) begin
      advance();
      n_checks++;
      if (obs[0] !== m_exp[0]) begin
        n_fail++;
        $display("FAIL rmid_model cyc=%0d got=%b want=%b", c, obs[0], m_exp[0]);
      end
    end
    n_checks++;
    if (obs[0][7] !== 1'b1 || obs[0][5:2] !== 4'd7) begin
      n_fail++;
      $display("FAIL rmid_pre got=%b want=YDA=1 BT=7", obs[0]);
    end
    #2 rst_m = 1'b0;
    #1;
    n_checks++;
    if (obs[0] !== 10'h001) begin
      n_fail++;
      $display("FAIL rmid_async_drop got=%b want=%b", obs[0], 10'h001);
    end
    advance();
    rst_m = 1'b1;
    for (int c = 0; c < 40; c++) begin
      advance();
      n_checks++;
      if (obs[0] !== m_exp[0]) begin
        n_fail++;
        $display("FAIL rmid_restart cyc=%0d got=%b want=%b", c, obs[0], m_exp[0]);
      end
      if (c == 1) begin
        n_checks++;
        if (obs[0] !== 10'b1000_0000_00) begin
          n_fail++;
          $display("FAIL rmid_first_w got=%b want=%b", obs[0], 10'b1000_0000_00);
        end
      end
    end
  endtask

  task automatic test_random();
    int seg;
    int c;
    c = 0;
    while (c < 1500) begin
      run_m = 1'($urandom_range(0, 1));
      seg   = int'($urandom_range(1, 120));
      for (int k = 0; k < seg; k++) begin
        advance();
        c++;
        n_checks++;
        if (obs[0] !== m_exp[0]) begin
          n_fail++;
          $display("FAIL random_model cyc=%0d got=%b want=%b", c, obs[0], m_exp[0]);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int last_hi [4];
    int last_we [4];
    bit prev_any [4];
    for (int i = 1; i < 4; i++) begin
      last_hi[i] = -1; last_we[i] = -1; prev_any[i] = 1'b0;
    end
    run_s = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      if (c >= 200 && (c % 37) == 0) run_s = 1'($urandom_range(0, 1));
      advance();
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (obs[i] !== m_exp[i]) begin
          n_fail++;
          $display("FAIL sweep_model inst=%0d cyc=%0d got=%b want=%b", i, c, obs[i], m_exp[i]);
        end
        n_checks++;
        if ($countones(obs[i][9:6]) > 1) begin
          n_fail++;
          $display("FAIL sweep_onehot inst=%0d cyc=%0d got=%b want<=1 high", i, c, obs[i][9:6]);
        end
        if (obs[i][9:6] != 4'b0000) begin
          if (!prev_any[i] && last_hi[i] >= 0) begin
            n_checks++;
            if (c - last_hi[i] - 1 < int'(div_of(i) - pw_of(i))) begin
              n_fail++;
              $display("FAIL sweep_gap inst=%0d got=%0d want>=%0d", i, c - last_hi[i] - 1,
                       div_of(i) - pw_of(i));
            end
          end
          last_hi[i] = c;
        end
        prev_any[i] = (obs[i][9:6] != 4'b0000);
        if (c < 200 && obs[i][1] === 1'b1) begin
          if (last_we[i] >= 0) begin
            n_checks++;
            if (c - last_we[i] != int'(4 * div_of(i) * bc_of(i))) begin
              n_fail++;
              $display("FAIL sweep_word_len inst=%0d got=%0d want=%0d", i, c - last_we[i],
                       4 * div_of(i) * bc_of(i));
            end
          end
          last_we[i] = c;
        end
      end
    end
  endtask

`ifdef TIMING_SINGLE_STEP_EN
  task automatic test_step();
    int hi [4];
    rst_m = 1'b0; run_m = 1'b0; step_m = 1'b0;
    @(negedge clk);
    rst_m = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 4; p++) hi[p] = 0;
      step_m = 1'b1;
      @(negedge clk);
      step_m = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        for (int p = 0; p < 4; p++) if (obs[0][9-p] === 1'b1) hi[p]++;
      end
      for (int p = 0; p < 4; p++) begin
        n_checks++;
        if (hi[p] != int'(pw_of(0))) begin
          n_fail++;
          $display("FAIL step_drive step=%0d phase=%0d got=%0d want=%0d", k, p, hi[p], pw_of(0));
        end
      end
      n_checks++;
      if (obs[0][5:2] !== 4'(k + 1) || obs[0][0] !== 1'b1) begin
        n_fail++;
        $display("FAIL step_bt step=%0d got=%b want BT=%0d STOPPED=1", k, obs[0], k + 1);
      end
    end
    rst_m = 1'b0;
    advance();
    rst_m = 1'b1;
    run_m = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step_m = (c == 30);
      advance();
      n_checks++;
      if (obs[0] !== m_exp[0]) begin
        n_fail++;
        $display("FAIL step_in_run cyc=%0d got=%b want=%b", c, obs[0], m_exp[0]);
      end
    end
    step_m = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_drain();
    test_reset_mid();
    test_random();
    test_sweep();
`ifdef TIMING_SINGLE_STEP_EN
    test_step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
